// File: rtl/perip_bus_arbiter_if.sv
// Bundle of both master ports and the shared peripheral bus around perip_bus_arbiter.
// The master modport is the arbiter's view: it masters the peripheral bus and answers the two masters.
// The slave modport is the environment's view: the two requesting masters plus the peripheral.
interface perip_bus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // master 0 (CPU MEM-stage data port)
   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic [1:0]    m0_mask;
   logic [DW-1:0] m0_rdata;
   logic          m0_ack;
   logic          m0_err;

   // master 1 (DMA / debug loader)
   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic [1:0]    m1_mask;
   logic [DW-1:0] m1_rdata;
   logic          m1_ack;
   logic          m1_err;

   // shared peripheral bus
   logic          perip_req;
   logic          perip_wen;
   logic [AW-1:0] perip_addr;
   logic [DW-1:0] perip_wdata;
   logic [1:0]    perip_wen_mask;
   logic [DW-1:0] perip_rdata;
   logic          perip_ack;

   modport master (
      input  m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
      output m0_rdata, m0_ack, m0_err,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
      output m1_rdata, m1_ack, m1_err,
      output perip_req, perip_wen, perip_addr, perip_wdata, perip_wen_mask,
      input  perip_rdata, perip_ack
   );

   modport slave (
      output m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
      input  m0_rdata, m0_ack, m0_err,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
      input  m1_rdata, m1_ack, m1_err,
      input  perip_req, perip_wen, perip_addr, perip_wdata, perip_wen_mask,
      output perip_rdata, perip_ack
   );
endinterface

// File: rtl/perip_bus_arbiter.sv
// Round-robin arbiter sharing one req/ack peripheral bus between two masters, with hung-access timeout.
// Latency: grant sampled in IDLE, perip_req the next cycle, master ack one cycle after perip_ack (3 cycles min).
// Backpressure: masters hold req until their ack; the slave stretches BUSY by withholding perip_ack.
module perip_bus_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic                cpu_clk,
   input  logic                cpu_rst,
   perip_bus_arbiter_if.master bus
);

   // TIMEOUT must be representable in CW bits; the abort fires when the counter reaches TIMEOUT-1.
   localparam bit            TIMEOUT_EN = (TIMEOUT != 0);
   localparam logic [CW-1:0] CNT_LAST   = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;

   // arbitration result for the current IDLE cycle
   logic          win_vld;
   logic          win_sel;
   logic          win_we;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata;
   logic [1:0]    win_mask;

   // transaction registers
   logic          gnt;
   logic          rr_last;
   logic [CW-1:0] cnt;
   logic          err_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [1:0]    mask_q;
   logic [DW-1:0] rdata0_q;
   logic [DW-1:0] rdata1_q;

   logic          timeout_hit;

   // Pick the winner: a lone requester wins outright, a tie goes to whoever did not win last.
   always_comb begin
      win_vld = bus.m0_req | bus.m1_req;
      if (bus.m0_req && bus.m1_req) begin
         win_sel = ~rr_last;
      end else begin
         win_sel = bus.m1_req;
      end
      if (win_sel) begin
         win_we    = bus.m1_we;
         win_addr  = bus.m1_addr;
         win_wdata = bus.m1_wdata;
         win_mask  = bus.m1_mask;
      end else begin
         win_we    = bus.m0_we;
         win_addr  = bus.m0_addr;
         win_wdata = bus.m0_wdata;
         win_mask  = bus.m0_mask;
      end
   end

   // Abort condition: slave silent for TIMEOUT BUSY cycles (never when the timeout is disabled).
   always_comb begin
      timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);
   end

   // State register; reset drops any in-flight transaction without an ack.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: IDLE -> BUSY on grant, BUSY -> RESP on ack or abort, RESP always back to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (win_vld) state_nxt = BUSY;
         BUSY: if (bus.perip_ack || timeout_hit) state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Transaction datapath: latch the winner's payload at grant, capture read data or abort at BUSY exit.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         gnt      <= 1'b0;
         rr_last  <= 1'b1;
         cnt      <= '0;
         err_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mask_q   <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  gnt     <= win_sel;
                  we_q    <= win_we;
                  addr_q  <= win_addr;
                  wdata_q <= win_wdata;
                  mask_q  <= win_mask;
                  cnt     <= '0;
                  err_q   <= 1'b0;
               end
            end
            BUSY: begin
               if (bus.perip_ack) begin
                  if (gnt) begin
                     rdata1_q <= bus.perip_rdata;
                  end else begin
                     rdata0_q <= bus.perip_rdata;
                  end
                  err_q   <= 1'b0;
                  rr_last <= gnt;
               end else if (timeout_hit) begin
                  if (gnt) begin
                     rdata1_q <= '0;
                  end else begin
                     rdata0_q <= '0;
                  end
                  err_q   <= 1'b1;
                  rr_last <= gnt;
               end else if (TIMEOUT_EN) begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode from state so that reset clears request, write enable, acks and errs immediately.
   always_comb begin
      bus.perip_req      = (state == BUSY);
      bus.perip_wen      = (state == BUSY) && we_q;
      bus.perip_addr     = addr_q;
      bus.perip_wdata    = wdata_q;
      bus.perip_wen_mask = mask_q;
      bus.m0_ack         = (state == RESP) && !gnt;
      bus.m0_err         = (state == RESP) && !gnt && err_q;
      bus.m0_rdata       = rdata0_q;
      bus.m1_ack         = (state == RESP) && gnt;
      bus.m1_err         = (state == RESP) && gnt && err_q;
      bus.m1_rdata       = rdata1_q;
   end

endmodule

// File: tb/tb_perip_bus_arbiter.sv
// Scoreboard bench for perip_bus_arbiter: expected transactions queued in grant order, checked on bus and acks.
// Slave model answers from the queue head after a per-transaction wait; masters hold req until their ack.
// DUT built with TIMEOUT=4 so the abort path is reachable in a few cycles.
module tb_perip_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   typedef struct {
      int          m;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  mask;
      logic [31:0] rdata;
      int          waitc;
      logic        err;
   } txn_t;

   logic cpu_clk = 1'b0;
   logic cpu_rst = 1'b1;

   perip_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   perip_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .CW(8)) dut (
      .cpu_clk (cpu_clk),
      .cpu_rst (cpu_rst),
      .bus     (bus.master)
   );

   always #5 cpu_clk = ~cpu_clk;

   int   checks = 0;
   int   errors = 0;
   txn_t exp_q[$];
   txn_t pend0[$];
   txn_t pend1[$];
   logic [31:0] mdl_rdata [2];
   logic outst [2];
   int   busy_cnt = 0;
   int   cyc = 0;
   int   last_ack_cyc = 0;
   bit   have_ack = 0;
   bit   idle_ack = 0;
   bit   mid_tweak = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic add(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] mask, input logic [31:0] rdata, input int waitc, input logic err);
      txn_t t;
      t.m = m; t.we = we; t.addr = addr; t.wdata = wdata; t.mask = mask;
      t.rdata = rdata; t.waitc = waitc; t.err = err;
      exp_q.push_back(t);
      if (m == 0) pend0.push_back(t);
      else pend1.push_back(t);
   endtask

   task automatic drive_master(input int n, input logic req, input txn_t t);
      if (n == 0) begin
         bus.m0_req = req; bus.m0_we = t.we; bus.m0_addr = t.addr;
         bus.m0_wdata = t.wdata; bus.m0_mask = t.mask;
      end else begin
         bus.m1_req = req; bus.m1_we = t.we; bus.m1_addr = t.addr;
         bus.m1_wdata = t.wdata; bus.m1_mask = t.mask;
      end
   endtask

   // Bounded wait for the scoreboard to drain, then two idle cycles.
   task automatic wait_done(input string tag);
      int k = 0;
      while ((exp_q.size() != 0 || pend0.size() != 0 || pend1.size() != 0) && k < 300) begin
         @(negedge cpu_clk);
         k++;
      end
      check_val({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      pend0.delete();
      pend1.delete();
      repeat (2) @(negedge cpu_clk);
   endtask

   // Monitor, slave model and master drivers share one negedge process so their ordering is fixed.
   initial begin
      txn_t e;
      txn_t blank;
      logic [1:0] acks;
      int n;
      blank = '{m: 0, we: 1'b0, addr: 32'h0, wdata: 32'h0, mask: 2'b00, rdata: 32'h0, waitc: 0, err: 1'b0};
      drive_master(0, 1'b0, blank);
      drive_master(1, 1'b0, blank);
      bus.perip_ack   = 1'b0;
      bus.perip_rdata = 32'h0;
      mdl_rdata[0] = 32'h0; mdl_rdata[1] = 32'h0;
      outst[0] = 1'b0; outst[1] = 1'b0;
      forever begin
         @(negedge cpu_clk);
         if (cpu_rst) begin
            busy_cnt = 0; have_ack = 0;
            mdl_rdata[0] = 32'h0; mdl_rdata[1] = 32'h0;
            outst[0] = 1'b0; outst[1] = 1'b0;
            bus.m0_req = 1'b0; bus.m1_req = 1'b0;
            bus.perip_ack = 1'b0;
         end else begin
            cyc++;
            acks = {bus.m1_ack, bus.m0_ack};
            // bus side: latched payload must match the transaction at the head of the queue
            if (bus.perip_req) begin
               busy_cnt++;
               if (exp_q.size() == 0) begin
                  check_val("bus_unexpected", 64'd1, 64'd0);
               end else begin
                  e = exp_q[0];
                  check_val("perip_addr", 64'(bus.perip_addr), 64'(e.addr));
                  check_val("perip_wdata", 64'(bus.perip_wdata), 64'(e.wdata));
                  check_val("perip_wen", 64'(bus.perip_wen), 64'(e.we));
                  check_val("perip_mask", 64'(bus.perip_wen_mask), 64'(e.mask));
                  if (busy_cnt == 1 && have_ack)
                     check_val("idle_gap", 64'((cyc - last_ack_cyc) >= 2), 64'd1);
               end
            end
            // master side: completion pulses
            if (acks != 2'b00) begin
               check_val("ack_onehot", 64'(acks == 2'b11), 64'd0);
               n = acks[1] ? 1 : 0;
               if (exp_q.size() == 0) begin
                  check_val("ack_unexpected", 64'(acks), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check_val("gnt_order", 64'(n), 64'(e.m));
                  check_val("err", 64'(n == 1 ? bus.m1_err : bus.m0_err), 64'(e.err));
                  check_val("rdata", 64'(n == 1 ? bus.m1_rdata : bus.m0_rdata), 64'(e.rdata));
                  check_val("other_rdata", 64'(n == 1 ? bus.m0_rdata : bus.m1_rdata), 64'(mdl_rdata[1-n]));
                  check_val("busy_len", 64'(busy_cnt), 64'(e.err ? TO : e.waitc + 1));
                  check_val("req_drop", 64'(bus.perip_req), 64'd0);
                  mdl_rdata[n] = e.rdata;
               end
               busy_cnt = 0;
               last_ack_cyc = cyc;
               have_ack = 1;
            end else if (bus.m0_err || bus.m1_err) begin
               check_val("err_without_ack", 64'({bus.m1_err, bus.m0_err}), 64'd0);
            end
            // slave model
            if (bus.perip_req && exp_q.size() != 0 && busy_cnt == exp_q[0].waitc + 1) begin
               bus.perip_ack   = 1'b1;
               bus.perip_rdata = exp_q[0].rdata;
            end else if (idle_ack && !bus.perip_req) begin
               bus.perip_ack   = 1'b1;
               bus.perip_rdata = 32'hBAAD_F00D;
            end else begin
               bus.perip_ack   = 1'b0;
               bus.perip_rdata = 32'hCCCC_CCCC;
            end
            // master drivers
            for (int i = 0; i < 2; i++) begin
               if (outst[i] && acks[i]) begin
                  if (i == 0) void'(pend0.pop_front());
                  else void'(pend1.pop_front());
                  outst[i] = 1'b0;
                  drive_master(i, 1'b0, blank);
               end
               if (!outst[i] && (i == 0 ? pend0.size() : pend1.size()) != 0) begin
                  drive_master(i, 1'b1, i == 0 ? pend0[0] : pend1[0]);
                  outst[i] = 1'b1;
               end else if (outst[i] && i == 0 && mid_tweak && bus.perip_req) begin
                  bus.m0_addr  = 32'hBAD0_0000;
                  bus.m0_wdata = 32'hFFFF_FFFF;
                  bus.m0_req   = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      int k;
      // reset state
      repeat (3) @(posedge cpu_clk);
      #2;
      check_val("rst_perip_req", 64'(bus.perip_req), 64'd0);
      check_val("rst_perip_wen", 64'(bus.perip_wen), 64'd0);
      check_val("rst_perip_addr", 64'(bus.perip_addr), 64'd0);
      check_val("rst_acks", 64'({bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err}), 64'd0);
      check_val("rst_rdata", 64'({bus.m1_rdata, bus.m0_rdata}), 64'd0);
      @(posedge cpu_clk); #2; cpu_rst = 1'b0;

      // m0 read with two wait states
      @(posedge cpu_clk); #1;
      add(0, 1'b0, 32'h8000_0010, 32'h0, 2'b10, 32'h1234_5678, 2, 1'b0);
      wait_done("m0_read");

      // m1 word write, zero-wait slave
      @(posedge cpu_clk); #1;
      add(1, 1'b1, 32'h8000_0020, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000, 0, 1'b0);
      wait_done("m1_write");

      // continuous contention: strict alternation starting with m0
      @(posedge cpu_clk); #1;
      add(0, 1'b0, 32'h8000_0100, 32'h0, 2'b10, $urandom, 0, 1'b0);
      add(1, 1'b1, 32'h8000_0104, $urandom, 2'b01, $urandom, 1, 1'b0);
      add(0, 1'b1, 32'h8000_0108, $urandom, 2'b00, $urandom, 0, 1'b0);
      add(1, 1'b0, 32'h8000_010C, 32'h0, 2'b10, $urandom, 2, 1'b0);
      wait_done("contention");

      // slave never acks: abort after TIMEOUT cycles, then a normal access
      @(posedge cpu_clk); #1;
      add(0, 1'b0, 32'h8000_0030, 32'h0, 2'b10, 32'h0, 1000, 1'b1);
      add(0, 1'b0, 32'h8000_0034, 32'h0, 2'b10, 32'hCAFE_0001, 1, 1'b0);
      wait_done("timeout");

      // perip_ack while IDLE must be ignored
      @(posedge cpu_clk); #2;
      idle_ack = 1;
      repeat (4) begin
         @(posedge cpu_clk); #2;
         check_val("idle_ack_ignored", 64'({bus.m1_ack, bus.m0_ack, bus.perip_req}), 64'd0);
      end
      idle_ack = 0;
      repeat (2) @(posedge cpu_clk);

      // m0 changes payload and drops req mid-BUSY: bus keeps the latched values, transaction completes
      #1;
      mid_tweak = 1;
      add(0, 1'b1, 32'h8000_0040, 32'h0BAD_CAFE, 2'b01, 32'h5A5A_0001, 2, 1'b0);
      wait_done("mid_busy_change");
      mid_tweak = 0;

      // asynchronous reset in the middle of a write
      @(posedge cpu_clk); #1;
      add(0, 1'b1, 32'h8000_0050, 32'h1111_2222, 2'b10, 32'h0, 1000, 1'b0);
      k = 0;
      while (!bus.perip_req && k < 20) begin
         @(negedge cpu_clk);
         k++;
      end
      check_val("rst_busy_reached", 64'(bus.perip_wen), 64'd1);
      @(posedge cpu_clk); #3;
      cpu_rst = 1'b1;
      #1;
      check_val("async_rst_req", 64'({bus.perip_req, bus.perip_wen}), 64'd0);
      check_val("async_rst_ack", 64'({bus.m1_ack, bus.m0_ack, bus.m1_err, bus.m0_err}), 64'd0);
      check_val("async_rst_rdata", 64'({bus.m1_rdata, bus.m0_rdata}), 64'd0);
      exp_q.delete();
      pend0.delete();
      pend1.delete();
      repeat (2) @(posedge cpu_clk);
      #2; cpu_rst = 1'b0;

      // after reset m0 wins the first contest again
      @(posedge cpu_clk); #1;
      add(0, 1'b0, 32'h8000_0200, 32'h0, 2'b10, 32'h0000_00A0, 0, 1'b0);
      add(1, 1'b0, 32'h8000_0204, 32'h0, 2'b10, 32'h0000_00A1, 0, 1'b0);
      wait_done("post_reset_contest");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
